// File: rtl/img_pkg.sv
// Shared image-processing constants and types used by the line buffer slice.
package img_pkg;

    localparam int DEF_PIC_WIDTH = 250;
    localparam int DEF_WIDTH     = 8;

    // How many complete earlier rows the line buffers currently hold.
    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_state_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel stream in / 3-row column stream out, as seen by the line buffer.
interface line_buffer_3row_if
    import img_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             valid_in;
    logic             sof;
    logic [WIDTH-1:0] din;
    logic             valid_out;
    logic [WIDTH-1:0] dout1;
    logic [WIDTH-1:0] dout2;
    logic [WIDTH-1:0] dout3;
    logic             line_end;

    // master produces pixels and consumes columns; slave is the line buffer
    modport master (
        output valid_in, sof, din,
        input  valid_out, dout1, dout2, dout3, line_end
    );

    modport slave (
        input  valid_in, sof, din,
        output valid_out, dout1, dout2, dout3, line_end
    );

endinterface

// File: rtl/line_buffer_3row_line_ram.sv
// Single-port RAM, combinational read of the old word, write on the clock edge.
module line_ram
    import img_pkg::*;
#(
    parameter int  DEPTH = DEF_PIC_WIDTH,
    parameter int  WIDTH = DEF_WIDTH,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: turns a raster pixel stream into vertical 3-pixel columns.
module line_buffer_3row
    import img_pkg::*;
#(
    parameter int PIC_WIDTH = DEF_PIC_WIDTH,
    parameter int WIDTH     = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    line_buffer_3row_if.slave  bus
);

    localparam int                COL_W    = addr_width(PIC_WIDTH);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(PIC_WIDTH - 1);

    logic             start;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_eff;
    logic [COL_W-1:0] col_next;
    logic             col_wrap;

    fill_state_t      fill_state;
    fill_state_t      fill_next;
    fill_state_t      fill_eff;
    logic             row1_ok;
    logic             row2_ok;

    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    logic             valid_q;
    logic             line_end_q;
    logic [WIDTH-1:0] dout1_q;
    logic [WIDTH-1:0] dout2_q;
    logic [WIDTH-1:0] dout3_q;

    // A start-of-frame pixel overrides the running column and fill level.
    assign start    = bus.valid_in && bus.sof;
    assign col_eff  = start ? '0 : col;
    assign col_wrap = (col_eff == COL_LAST);
    assign col_next = col_wrap ? '0 : col_eff + COL_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
        end else if (bus.valid_in) begin
            col <= col_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_state <= FILL_EMPTY;
        end else begin
            fill_state <= fill_next;
        end
    end

    always_comb begin
        fill_next = fill_state;
        if (bus.valid_in) begin
            fill_next = fill_eff;
            if (col_wrap) begin
                unique case (fill_eff)
                    FILL_EMPTY: fill_next = FILL_ONE;
                    default:    fill_next = FILL_FULL;
                endcase
            end
        end
    end

    always_comb begin
        fill_eff = start ? FILL_EMPTY : fill_state;
        row1_ok  = (fill_eff != FILL_EMPTY);
        row2_ok  = (fill_eff == FILL_FULL);
    end

    // LB_A holds row y-1; its old word shifts down into LB_B (row y-2).
    line_ram #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH)
    ) lb_a (
        .clk   (clk),
        .we    (bus.valid_in),
        .addr  (col_eff),
        .wdata (bus.din),
        .rdata (rd_a)
    );

    line_ram #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH)
    ) lb_b (
        .clk   (clk),
        .we    (bus.valid_in),
        .addr  (col_eff),
        .wdata (rd_a),
        .rdata (rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            line_end_q <= 1'b0;
            dout1_q    <= '0;
            dout2_q    <= '0;
            dout3_q    <= '0;
        end else if (bus.valid_in) begin
            valid_q    <= 1'b1;
            line_end_q <= col_wrap;
            dout3_q    <= bus.din;
            dout2_q    <= row1_ok ? rd_a : '0;
            dout1_q    <= row2_ok ? rd_b : '0;
        end else begin
            valid_q    <= 1'b0;
            line_end_q <= 1'b0;
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.line_end  = line_end_q;
    assign bus.dout1     = dout1_q;
    assign bus.dout2     = dout2_q;
    assign bus.dout3     = dout3_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: directed rows plus random traffic against a row-array model.
module tb_line_buffer_3row;

    localparam int PW = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    line_buffer_3row_if #(.WIDTH(W)) bus ();

    line_buffer_3row #(
        .PIC_WIDTH (PW),
        .WIDTH     (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: the image as whole rows; the two previous rows are kept as arrays.
    int         m_col;
    int         m_row;
    logic [W-1:0] row_cur [PW];
    logic [W-1:0] row_up1 [PW];
    logic [W-1:0] row_up2 [PW];

    logic         exp_v;
    logic         exp_le;
    logic [W-1:0] exp_d1;
    logic [W-1:0] exp_d2;
    logic [W-1:0] exp_d3;

    task automatic model_reset();
        m_col  = 0;
        m_row  = 0;
        exp_v  = 1'b0;
        exp_le = 1'b0;
        exp_d1 = '0;
        exp_d2 = '0;
        exp_d3 = '0;
    endtask

    task automatic model_pixel(input logic s, input logic [W-1:0] d);
        if (s) begin
            m_col = 0;
            m_row = 0;
        end
        exp_v  = 1'b1;
        exp_le = (m_col == PW - 1);
        exp_d3 = d;
        exp_d2 = (m_row >= 1) ? row_up1[m_col] : '0;
        exp_d1 = (m_row >= 2) ? row_up2[m_col] : '0;
        row_cur[m_col] = d;
        m_col++;
        if (m_col == PW) begin
            row_up2 = row_up1;
            row_up1 = row_cur;
            m_row++;
            m_col = 0;
        end
    endtask

    task automatic model_idle();
        exp_v  = 1'b0;
        exp_le = 1'b0;
    endtask

    task automatic check_output(input string tag);
        logic [3*W+1:0] observed;
        logic [3*W+1:0] expected;
        observed = {bus.valid_out, bus.line_end, bus.dout1, bus.dout2, bus.dout3};
        expected = {exp_v, exp_le, exp_d1, exp_d2, exp_d3};
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed v=%0b le=%0b d1=%0d d2=%0d d3=%0d, expected v=%0b le=%0b d1=%0d d2=%0d d3=%0d",
                   tag, bus.valid_out, bus.line_end, bus.dout1, bus.dout2, bus.dout3,
                   exp_v, exp_le, exp_d1, exp_d2, exp_d3);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic s, input logic [W-1:0] d, input string tag);
        @(negedge clk);
        bus.valid_in = v;
        bus.sof      = s;
        bus.din      = d;
        if (v) begin
            model_pixel(s, d);
        end else begin
            model_idle();
        end
        @(posedge clk);
        #1;
        check_output(tag);
    endtask

    // Reset is held while a pixel is presented, so reset must win over valid_in.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst          = 1'b1;
        bus.valid_in = 1'b1;
        bus.sof      = 1'b0;
        bus.din      = 8'hAA;
        model_reset();
        @(posedge clk);
        #1;
        check_output(tag);
        @(negedge clk);
        rst          = 1'b0;
        bus.valid_in = 1'b0;
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.sof      = 1'b0;
        bus.din      = '0;
        model_reset();

        apply_reset("reset");

        for (int p = 1; p <= 10; p++) begin
            apply_stimulus(1'b1, p == 1, 8'(p), "fill_rows");
        end
        repeat (3) apply_stimulus(1'b0, 1'b0, 8'h00, "gap_hold");
        for (int p = 11; p <= 14; p++) begin
            apply_stimulus(1'b1, 1'b0, 8'(p), "resume");
        end

        apply_stimulus(1'b1, 1'b1, 8'd20, "sof_mid_row");
        apply_stimulus(1'b1, 1'b0, 8'd21, "after_sof");
        apply_stimulus(1'b0, 1'b1, 8'd99, "sof_no_valid");
        for (int p = 22; p <= 27; p++) begin
            apply_stimulus(1'b1, 1'b0, 8'(p), "refill");
        end
        for (int p = 50; p <= 55; p++) begin
            apply_stimulus(1'b1, 1'b0, 8'(p), "third_row");
        end

        apply_reset("reset_mid_row");
        for (int p = 30; p <= 37; p++) begin
            apply_stimulus(1'b1, 1'b0, 8'(p), "after_reset");
        end

        $display("[TB] random traffic phase");
        apply_stimulus(1'b1, 1'b1, 8'($urandom), "rand_sof");
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic s;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) begin
                apply_reset("rand_reset");
            end else begin
                apply_stimulus(v, s, 8'($urandom), "rand_pixel");
            end
        end
        apply_stimulus(1'b0, 1'b0, 8'h00, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
